// File: rtl/md_unit_pkg.sv
// md_unit_pkg
//   Shared definitions for the multiply/divide unit and the decoder/controller
//   that generates its requests.
//   Contents:
//     MD_OP_WIDTH  width of the mdOp request field
//     MD_OP_*      mdOp encodings (6 and 7 are reserved)
//     mdState_t    control state of the unit
//     isArithOp()  true for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
package md_unit_pkg;

    localparam int MD_OP_WIDTH = 3;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULT  = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULTU = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV   = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU  = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTHI  = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTLO  = 3'd5;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } mdState_t;

    function automatic logic isArithOp(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MULT)  || (op == MD_OP_MULTU) ||
               (op == MD_OP_DIV)   || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if
//   Request/response bundle between the EX stage and the multiply/divide unit.
//   Signals:
//     start   one-cycle request strobe from EX
//     mdOp    operation select (see md_unit_pkg MD_OP_*)
//     srcA    rs operand (forwarded register value)
//     srcB    rt operand (forwarded register value)
//     busy    high while an arithmetic op is in flight (registered)
//     hiData  architectural HI
//     loData  architectural LO
//   Modports:
//     master  pipeline side, drives the request
//     slave   md_unit side, answers with busy/HI/LO
interface md_unit_if;
    import md_unit_pkg::*;

    logic                   start;
    logic [MD_OP_WIDTH-1:0] mdOp;
    logic [31:0]            srcA;
    logic [31:0]            srcB;
    logic                   busy;
    logic [31:0]            hiData;
    logic [31:0]            loData;

    modport master (
        output start, mdOp, srcA, srcB,
        input  busy, hiData, loData
    );

    modport slave (
        input  start, mdOp, srcA, srcB,
        output busy, hiData, loData
    );

endinterface

// File: rtl/md_unit_divider.sv
// md_divider
//   Combinational 32-bit divider with MIPS result rules.
//   Ports:
//     dividend   numerator (rs)
//     divisor    denominator (rt)
//     isSigned   1 = DIV semantics, 0 = DIVU semantics
//     quotient   quotient, truncated toward zero
//     remainder  remainder, carrying the sign of the dividend
//     divByZero  divisor is zero; quotient/remainder are meaningless then
module md_divider (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        isSigned,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        divByZero
);

    logic        negA;
    logic        negB;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] safeB;
    logic [31:0] magQ;
    logic [31:0] magR;

    // Signed division is done on magnitudes and the signs are reapplied
    // afterwards. This gives truncation toward zero and a remainder that
    // follows the dividend. The 0x80000000 / -1 overflow case falls out
    // naturally: the magnitude 0x80000000 divided by 1 is 0x80000000, and the
    // quotient sign is positive so it is left as-is.
    // A zero divisor is replaced by 1 so the divider never sees /0; the
    // caller uses divByZero to discard the result.
    always_comb begin
        divByZero = (divisor == 32'd0);
        negA      = isSigned & dividend[31];
        negB      = isSigned & divisor[31];
        magA      = negA ? (~dividend + 32'd1) : dividend;
        magB      = negB ? (~divisor + 32'd1) : divisor;
        safeB     = divByZero ? 32'd1 : magB;
        magQ      = magA / safeB;
        magR      = magA % safeB;
        quotient  = (negA ^ negB) ? (~magQ + 32'd1) : magQ;
        remainder = negA ? (~magR + 32'd1) : magR;
    end

endmodule

// File: rtl/md_unit.sv
// md_unit
//   Multiply/divide unit owning the architectural HI/LO registers.
//   MULT/MULTU/DIV/DIVU compute their result at the accept edge into a pending
//   register and commit it after a fixed busy period; MTHI/MTLO write
//   immediately.
//   Parameters:
//     MULT_CYCLES  busy duration of MULT/MULTU (>= 1)
//     DIV_CYCLES   busy duration of DIV/DIVU (>= 1)
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous active-high reset, clears all state
//     md     md_unit_if.slave request/response bundle
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdState_t   state;
    mdState_t   stateNext;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;
    logic [63:0] pending;
    logic [63:0] pendingNext;
    logic        pendingWrite;
    logic        pendingWriteNext;
    logic [31:0] hiReg;
    logic [31:0] hiNext;
    logic [31:0] loReg;
    logic [31:0] loNext;

    logic [63:0] prodSigned;
    logic [63:0] prodUnsigned;
    logic [31:0] divQuotient;
    logic [31:0] divRemainder;
    logic        divByZero;

    // Multiplying the sign-extended operands modulo 2^64 gives the exact
    // signed product; zero-extension gives the unsigned one.
    assign prodSigned   = {{32{md.srcA[31]}}, md.srcA} * {{32{md.srcB[31]}}, md.srcB};
    assign prodUnsigned = {32'd0, md.srcA} * {32'd0, md.srcB};

    md_divider divider (
        .dividend  (md.srcA),
        .divisor   (md.srcB),
        .isSigned  (md.mdOp == MD_OP_DIV),
        .quotient  (divQuotient),
        .remainder (divRemainder),
        .divByZero (divByZero)
    );

    // State register. Reset aborts any op in flight, so the pending result
    // is dropped along with the counter and HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= MD_IDLE;
            count        <= '0;
            pending      <= '0;
            pendingWrite <= 1'b0;
            hiReg        <= '0;
            loReg        <= '0;
        end else begin
            state        <= stateNext;
            count        <= countNext;
            pending      <= pendingNext;
            pendingWrite <= pendingWriteNext;
            hiReg        <= hiNext;
            loReg        <= loNext;
        end
    end

    // Next-state logic. Requests are only looked at while idle, so a start
    // during busy is ignored. The counter holds the number of edges left
    // before commit; the edge that takes it from 1 to 0 writes HI/LO and
    // drops busy. A divide by zero still runs the full busy period but
    // leaves pendingWrite clear so nothing is committed.
    always_comb begin
        stateNext        = state;
        countNext        = count;
        pendingNext      = pending;
        pendingWriteNext = pendingWrite;
        hiNext           = hiReg;
        loNext           = loReg;

        case (state)
            MD_IDLE: begin
                if (md.start) begin
                    if (isArithOp(md.mdOp)) begin
                        stateNext = MD_BUSY;
                    end
                    case (md.mdOp)
                        MD_OP_MULT: begin
                            pendingNext      = prodSigned;
                            pendingWriteNext = 1'b1;
                            countNext        = CNT_W'(MULT_CYCLES);
                        end
                        MD_OP_MULTU: begin
                            pendingNext      = prodUnsigned;
                            pendingWriteNext = 1'b1;
                            countNext        = CNT_W'(MULT_CYCLES);
                        end
                        MD_OP_DIV, MD_OP_DIVU: begin
                            pendingNext      = {divRemainder, divQuotient};
                            pendingWriteNext = ~divByZero;
                            countNext        = CNT_W'(DIV_CYCLES);
                        end
                        MD_OP_MTHI: hiNext = md.srcA;
                        MD_OP_MTLO: loNext = md.srcA;
                        default: ;
                    endcase
                end
            end
            MD_BUSY: begin
                if (count <= CNT_W'(1)) begin
                    stateNext        = MD_IDLE;
                    countNext        = '0;
                    pendingWriteNext = 1'b0;
                    if (pendingWrite) begin
                        hiNext = pending[63:32];
                        loNext = pending[31:0];
                    end
                end else begin
                    countNext = count - CNT_W'(1);
                end
            end
            default: stateNext = MD_IDLE;
        endcase
    end

    assign md.busy   = (state == MD_BUSY);
    assign md.hiData = hiReg;
    assign md.loData = loReg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
//   Directed testbench for md_unit: arithmetic results, busy duration,
//   MTHI/MTLO, ignored requests and asynchronous reset mid-operation.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk;
    logic reset;
    int   testCount;
    int   failCount;
    logic [31:0] mHi;
    logic [31:0] mLo;

    md_unit_if mdBus ();

    md_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mdBus.slave)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for exactly one rising edge, returning just after it
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdBus.start = 1'b1;
        mdBus.mdOp  = op;
        mdBus.srcA  = a;
        mdBus.srcB  = b;
        @(posedge clk);
        #1;
        mdBus.start = 1'b0;
    endtask

    // Issue an op, check HI/LO stay hidden while busy, count busy cycles,
    // then check the committed HI/LO
    task automatic runOp(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int expCycles,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int cycles;
        cycles = 0;
        applyStimulus(op, a, b);
        @(negedge clk);
        if (expCycles > 0) begin
            checkOutput({tag, "_hiHidden"}, mdBus.hiData, mHi);
            checkOutput({tag, "_loHidden"}, mdBus.loData, mLo);
        end
        while (mdBus.busy === 1'b1 && cycles < 60) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_cycles"}, 32'(cycles), 32'(expCycles));
        checkOutput({tag, "_hi"}, mdBus.hiData, expHi);
        checkOutput({tag, "_lo"}, mdBus.loData, expLo);
        mHi = expHi;
        mLo = expLo;
    endtask

    initial begin
        int cycles;
        testCount   = 0;
        failCount   = 0;
        mHi         = 32'd0;
        mLo         = 32'd0;
        reset       = 1'b1;
        mdBus.start = 1'b0;
        mdBus.mdOp  = 3'd0;
        mdBus.srcA  = 32'd0;
        mdBus.srcB  = 32'd0;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_busy", 32'(mdBus.busy), 32'd0);
        checkOutput("reset_hi", mdBus.hiData, 32'd0);
        checkOutput("reset_lo", mdBus.loData, 32'd0);

        // busy must not follow start combinationally
        @(negedge clk);
        mdBus.start = 1'b1;
        mdBus.mdOp  = MD_OP_MULT;
        #1;
        checkOutput("busy_not_comb", 32'(mdBus.busy), 32'd0);
        mdBus.start = 1'b0;

        runOp("mult_neg",  MD_OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
        runOp("multu_max", MD_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
        runOp("div_m7_2",  MD_OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("div_ovf",   MD_OP_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
        runOp("div_7_m2",  MD_OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
        runOp("divu_big",  MD_OP_DIVU,  32'hFFFFFFFF, 32'd16,       10, 32'h0000000F, 32'h0FFFFFFF);
        runOp("mthi",      MD_OP_MTHI,  32'h12345678, 32'd0,        0,  32'h12345678, 32'h0FFFFFFF);
        runOp("divu_zero", MD_OP_DIVU,  32'd5,        32'd0,        10, 32'h12345678, 32'h0FFFFFFF);
        runOp("div_zero",  MD_OP_DIV,   32'hFFFFFFF9, 32'd0,        10, 32'h12345678, 32'h0FFFFFFF);
        runOp("mtlo",      MD_OP_MTLO,  32'h00000055, 32'd0,        0,  32'h12345678, 32'h00000055);

        // MTLO arriving while MULT is busy must be dropped
        applyStimulus(MD_OP_MULT, 32'd3, 32'd4);
        applyStimulus(MD_OP_MTLO, 32'h0000AAAA, 32'd0);
        cycles = 0;
        @(negedge clk);
        while (mdBus.busy === 1'b1 && cycles < 60) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput("mtlo_busy_cycles", 32'(cycles), 32'd4);
        checkOutput("mtlo_busy_hi", mdBus.hiData, 32'd0);
        checkOutput("mtlo_busy_lo", mdBus.loData, 32'd12);

        // Reserved opcode does nothing
        applyStimulus(3'd6, 32'hDEADBEEF, 32'h0BADF00D);
        @(negedge clk);
        checkOutput("reserved_busy", 32'(mdBus.busy), 32'd0);
        checkOutput("reserved_hi", mdBus.hiData, 32'd0);
        checkOutput("reserved_lo", mdBus.loData, 32'd12);

        // Asynchronous reset between edges aborts a divide
        applyStimulus(MD_OP_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        checkOutput("abort_busy_before", 32'(mdBus.busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(mdBus.busy), 32'd0);
        checkOutput("abort_hi", mdBus.hiData, 32'd0);
        checkOutput("abort_lo", mdBus.loData, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("abort_late_busy", 32'(mdBus.busy), 32'd0);
        checkOutput("abort_late_hi", mdBus.hiData, 32'd0);
        checkOutput("abort_late_lo", mdBus.loData, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
